// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, ALU op codes
// and the opcode classes produced by opcode_class.
package multicycle_ctrl_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned ST_W    = 3;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned RET_W   = 8;

  typedef enum logic [ST_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [OP_W-1:0] OPC_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OPC_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OPC_BRANCH = 7'b1100011;

  localparam logic [ALUOP_W-1:0] ALUOP_MEM    = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_R      = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_I      = 2'b11;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } op_class_t;

endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// Combinational opcode classifier: maps a 7-bit opcode to its instruction class
// and flags anything outside the supported set as illegal.
module opcode_class
  import multicycle_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] i_opcode,
  output op_class_t       o_class,
  output logic            o_legal
);

  always_comb begin
    o_class = CLS_R;
    o_legal = 1'b1;
    case (i_opcode)
      OPC_R:      o_class = CLS_R;
      OPC_I:      o_class = CLS_I;
      OPC_LOAD:   o_class = CLS_LOAD;
      OPC_STORE:  o_class = CLS_STORE;
      OPC_BRANCH: o_class = CLS_BRANCH;
      default:    o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: sequences fetch/decode/exec/mem/writeback,
// drives datapath strobes, tracks illegal opcodes and counts retired instructions.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               ir_we,
  output logic               pc_we,
  output logic               pc_src,
  output logic               regwrite,
  output logic               memread,
  output logic               memwrite,
  output logic               aluSrc,
  output logic               memtoreg,
  output logic [ALUOP_W-1:0] Aluop,
  output logic [ST_W-1:0]    state,
  output logic               illegal,
  output logic [RET_W-1:0]   retired
);

  state_t           r_state;
  state_t           w_next;
  logic [OP_W-1:0]  r_op_q;
  logic [OP_W-1:0]  w_cls_opcode;
  op_class_t        w_class;
  logic             w_legal;
  logic             r_illegal;
  logic [RET_W-1:0] r_retired;

  // DECODE classifies the live opcode; every later state works from the latched copy.
  assign w_cls_opcode = (r_state == ST_DECODE) ? opcode : r_op_q;

  opcode_class u_opcode_class (
    .i_opcode (w_cls_opcode),
    .o_class  (w_class),
    .o_legal  (w_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_q    <= '0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      if (r_state == ST_DECODE) begin
        r_op_q <= opcode;
        if (!w_legal) r_illegal <= 1'b1;
      end
      if (pc_we) r_retired <= r_retired + RET_W'(1);
    end
  end

  always_comb begin
    w_next   = r_state;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    aluSrc   = 1'b0;
    memtoreg = 1'b0;
    Aluop    = '0;
    case (r_state)
      ST_FETCH: begin
        if (run) begin
          ir_we  = 1'b1;
          w_next = ST_DECODE;
        end
      end
      ST_DECODE: w_next = w_legal ? ST_EXEC : ST_HALT;
      ST_EXEC: begin
        case (w_class)
          CLS_R: begin
            Aluop  = ALUOP_R;
            w_next = ST_WB;
          end
          CLS_I: begin
            Aluop  = ALUOP_I;
            aluSrc = 1'b1;
            w_next = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            Aluop  = ALUOP_MEM;
            aluSrc = 1'b1;
            w_next = ST_MEM;
          end
          CLS_BRANCH: begin
            Aluop  = ALUOP_BRANCH;
            pc_we  = 1'b1;
            pc_src = zero;
            w_next = ST_FETCH;
          end
          default: w_next = ST_FETCH;
        endcase
      end
      // Strobe is held every cycle until the memory reports completion.
      ST_MEM: begin
        if (w_class == CLS_LOAD) begin
          memread = 1'b1;
          if (mem_ready) w_next = ST_WB;
        end else if (w_class == CLS_STORE) begin
          memwrite = 1'b1;
          if (mem_ready) begin
            pc_we  = 1'b1;
            w_next = ST_FETCH;
          end
        end else begin
          w_next = ST_FETCH;
        end
      end
      ST_WB: begin
        regwrite = 1'b1;
        pc_we    = 1'b1;
        memtoreg = (w_class == CLS_LOAD);
        w_next   = ST_FETCH;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_FETCH;
    endcase
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: each cycle's stimulus and the
// full expected output vector are queued, then applied and checked in order.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset, run, zero, mem_ready;
  logic [6:0] opcode;
  logic       ir_we, pc_we, pc_src, regwrite, memread, memwrite, aluSrc, memtoreg;
  logic [1:0] Aluop;
  logic [2:0] state;
  logic       illegal;
  logic [7:0] retired;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .regwrite  (regwrite),
    .memread   (memread),
    .memwrite  (memwrite),
    .aluSrc    (aluSrc),
    .memtoreg  (memtoreg),
    .Aluop     (Aluop),
    .state     (state),
    .illegal   (illegal),
    .retired   (retired)
  );

  // Strobe bit positions: {ir_we, pc_we, pc_src, regwrite, memread, memwrite, aluSrc, memtoreg}
  localparam logic [7:0] S_IR  = 8'h80;
  localparam logic [7:0] S_PCW = 8'h40;
  localparam logic [7:0] S_PCS = 8'h20;
  localparam logic [7:0] S_RW  = 8'h10;
  localparam logic [7:0] S_MR  = 8'h08;
  localparam logic [7:0] S_MW  = 8'h04;
  localparam logic [7:0] S_AS  = 8'h02;
  localparam logic [7:0] S_MTR = 8'h01;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic        rst;
    logic        run;
    logic [6:0]  opc;
    logic        zero;
    logic        mrdy;
    logic [21:0] exp;
  } step_t;

  step_t      q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_ret;
  logic       m_ill;
  string      g_test;

  function automatic logic [21:0] ex(input logic [2:0] st, input logic [7:0] strb,
                                     input logic [1:0] aop);
    return {st, strb, aop, m_ill, m_ret};
  endfunction

  task automatic push(input logic rst, input logic rn, input logic [6:0] opc,
                      input logic z, input logic mr, input logic [21:0] e);
    step_t s;
    s.rst = rst; s.run = rn; s.opc = opc; s.zero = z; s.mrdy = mr; s.exp = e;
    q.push_back(s);
  endtask

  task automatic drain(input string name);
    step_t       s;
    logic [21:0] obs;
    int          idx;
    g_test = name;
    idx = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      reset = s.rst; run = s.run; opcode = s.opc; zero = s.zero; mem_ready = s.mrdy;
      @(negedge clk);
      obs = {state, ir_we, pc_we, pc_src, regwrite, memread, memwrite, aluSrc, memtoreg,
             Aluop, illegal, retired};
      n_cmp++;
      assert (obs === s.exp) else begin
        n_bad++;
        $error("FAIL %s step%0d observed=%h expected=%h", g_test, idx, obs, s.exp);
      end
      idx++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, OP_R, 1'b0, 1'b0, ex(3'd0, 8'h00, 2'b00));
  endtask

  task automatic alu(input logic [6:0] opc, input bit is_i);
    push(1'b0, 1'b1, opc,    1'b0, 1'b0, ex(3'd0, S_IR, 2'b00));
    push(1'b0, 1'b1, opc,    1'b0, 1'b0, ex(3'd1, 8'h00, 2'b00));
    push(1'b0, 1'b1, OP_BAD, 1'b0, 1'b0, ex(3'd2, is_i ? S_AS : 8'h00, is_i ? 2'b11 : 2'b10));
    push(1'b0, 1'b1, OP_BAD, 1'b0, 1'b0, ex(3'd4, S_RW | S_PCW, 2'b00));
    m_ret = m_ret + 8'd1;
  endtask

  task automatic load(input int waits);
    push(1'b0, 1'b1, OP_LD, 1'b0, 1'b0, ex(3'd0, S_IR, 2'b00));
    push(1'b0, 1'b1, OP_LD, 1'b0, 1'b0, ex(3'd1, 8'h00, 2'b00));
    push(1'b0, 1'b1, OP_ST, 1'b0, 1'b0, ex(3'd2, S_AS, 2'b00));
    for (int i = 0; i < waits; i++) push(1'b0, 1'b1, OP_ST, 1'b0, 1'b0, ex(3'd3, S_MR, 2'b00));
    push(1'b0, 1'b1, OP_ST, 1'b0, 1'b1, ex(3'd3, S_MR, 2'b00));
    push(1'b0, 1'b1, OP_ST, 1'b0, 1'b0, ex(3'd4, S_RW | S_PCW | S_MTR, 2'b00));
    m_ret = m_ret + 8'd1;
  endtask

  task automatic store(input int waits);
    push(1'b0, 1'b1, OP_ST, 1'b0, 1'b0, ex(3'd0, S_IR, 2'b00));
    push(1'b0, 1'b1, OP_ST, 1'b0, 1'b0, ex(3'd1, 8'h00, 2'b00));
    push(1'b0, 1'b1, OP_LD, 1'b0, 1'b0, ex(3'd2, S_AS, 2'b00));
    for (int i = 0; i < waits; i++) push(1'b0, 1'b1, OP_LD, 1'b0, 1'b0, ex(3'd3, S_MW, 2'b00));
    push(1'b0, 1'b1, OP_LD, 1'b0, 1'b1, ex(3'd3, S_MW | S_PCW, 2'b00));
    m_ret = m_ret + 8'd1;
  endtask

  task automatic branch(input logic z);
    push(1'b0, 1'b1, OP_BR,  z, 1'b0, ex(3'd0, S_IR, 2'b00));
    push(1'b0, 1'b1, OP_BR,  z, 1'b0, ex(3'd1, 8'h00, 2'b00));
    push(1'b0, 1'b1, OP_BAD, z, 1'b0, ex(3'd2, S_PCW | (z ? S_PCS : 8'h00), 2'b01));
    m_ret = m_ret + 8'd1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    m_ret = 8'd0; m_ill = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, run=0 hold, and reset winning over run in FETCH
    idle(2);
    push(1'b1, 1'b1, OP_R, 1'b0, 1'b0, ex(3'd0, S_IR, 2'b00));
    idle(1);
    drain("reset");

    alu(OP_R, 1'b0);
    alu(OP_I, 1'b1);
    drain("alu");

    load(2);
    load(0);
    drain("load");

    store(1);
    store(0);
    drain("store");

    branch(1'b1);
    branch(1'b0);
    idle(3);
    drain("branch");

    // Reset during a stalled STORE memory phase
    push(1'b0, 1'b1, OP_ST, 1'b0, 1'b0, ex(3'd0, S_IR, 2'b00));
    push(1'b0, 1'b1, OP_ST, 1'b0, 1'b0, ex(3'd1, 8'h00, 2'b00));
    push(1'b0, 1'b1, OP_ST, 1'b0, 1'b0, ex(3'd2, S_AS, 2'b00));
    push(1'b0, 1'b1, OP_ST, 1'b0, 1'b0, ex(3'd3, S_MW, 2'b00));
    push(1'b1, 1'b1, OP_ST, 1'b0, 1'b0, ex(3'd3, S_MW, 2'b00));
    m_ret = 8'd0;
    idle(1);
    drain("st_reset");

    // Illegal opcode parks in HALT until reset
    push(1'b0, 1'b1, OP_BAD, 1'b0, 1'b0, ex(3'd0, S_IR, 2'b00));
    push(1'b0, 1'b1, OP_BAD, 1'b0, 1'b0, ex(3'd1, 8'h00, 2'b00));
    m_ill = 1'b1;
    for (int i = 0; i < 10; i++) push(1'b0, 1'b1, OP_R, 1'b1, 1'b1, ex(3'd5, 8'h00, 2'b00));
    push(1'b1, 1'b1, OP_R, 1'b0, 1'b0, ex(3'd5, 8'h00, 2'b00));
    m_ill = 1'b0;
    idle(1);
    alu(OP_R, 1'b0);
    drain("illegal");

    // 256 retirements from reset wrap the counter back to zero
    push(1'b1, 1'b0, OP_R, 1'b0, 1'b0, ex(3'd0, 8'h00, 2'b00));
    m_ret = 8'd0;
    for (int i = 0; i < 256; i++) alu(OP_R, 1'b0);
    idle(2);
    drain("wrap");
    n_cmp++;
    assert (retired === 8'd0) else begin
      n_bad++;
      $error("FAIL wrap_final observed=%0d expected=0", retired);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports named clk and reset as in the rest of the processor.
REQ-002 SHALL have these ports, one per line:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- run  in  1  allow fetch of next instruction
- opcode  in  7  instruction[6:0] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  data memory access complete
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC
- pc_src  out  1  1 = branch target, 0 = PC+4
- regwrite  out  1  register file write enable
- memread  out  1  data memory read strobe
- memwrite  out  1  data memory write strobe
- aluSrc  out  1  1 = imm_data, 0 = readdata2
- memtoreg  out  1  1 = read_data, 0 = ALU result
- Aluop  out  2  to ALU_control
- state  out  3  current FSM state, for debug
- illegal  out  1  sticky illegal-opcode flag
- retired  out  8  count of retired instructions

Function
REQ-003 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to FETCH.
REQ-004 FETCH: ir_we=1 when run=1; when run=1, next state is DECODE; otherwise stay in FETCH with all strobes 0.
REQ-005 DECODE: latch opcode into an internal op_q; every later state decodes op_q, so opcode changes after DECODE SHALL be ignored.
REQ-006 Legal opcodes: R=0110011, I-ALU=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011; any other opcode in DECODE SHALL go to HALT and set illegal=1.
REQ-007 EXEC Aluop: R=10, I-ALU=11, LOAD/STORE=00, BRANCH=01; aluSrc=1 for I-ALU, LOAD and STORE, else 0.
REQ-008 EXEC transitions: R/I-ALU to WB; LOAD/STORE to MEM; BRANCH to FETCH.
REQ-009 BRANCH in EXEC: pc_we=1, and pc_src=zero in that cycle.
REQ-010 MEM: memread (LOAD) or memwrite (STORE) SHALL stay asserted every MEM cycle until mem_ready=1 is sampled; a LOAD then goes to WB, a STORE goes to FETCH with pc_we=1 in that final MEM cycle.
REQ-011 WB: regwrite=1 and pc_we=1 for exactly one cycle; memtoreg=1 only for LOAD; next state FETCH.
REQ-012 Minimum latency in cycles, including FETCH: R/I-ALU 4, LOAD 5 (+1 per mem_ready wait), STORE 4 (+1 per wait), BRANCH 3.
REQ-013 Exactly one pc_we pulse per instruction; regwrite and memwrite SHALL never both be 1; memread and memwrite SHALL never both be 1.
REQ-014 retired SHALL increment on every cycle with pc_we=1 and wrap 255 to 0.
REQ-015 HALT: all strobes 0, stays in HALT regardless of run, and is left only by reset.
REQ-016 Outputs not listed for a state SHALL be 0 in that state.

Reset
REQ-017 With reset=1 at a clock edge, from any state (including mid-MEM wait or HALT), the next state SHALL be FETCH.
REQ-018 The same edge SHALL clear op_q, illegal and retired to 0.
REQ-019 After reset, every output SHALL be 0 except state=0.
REQ-020 Reset SHALL take priority over run and mem_ready.

Structure
REQ-021 A shared package SHALL hold the state encodings, the five opcode constants and the four Aluop codes, for use by control_unit and the bench.
REQ-022 The opcode classifier (opcode in; class and legal out) SHALL be one combinational sub-module named opcode_class; everything else SHALL be flat.

Verification
REQ-023 R-type 0110011 with run=1 -> states 0,1,2,4,0; Aluop=10 in EXEC; regwrite=pc_we=1 only in WB; retired 0->1.
REQ-024 LOAD with mem_ready low for 2 MEM cycles -> memread=1 for 3 cycles, then WB with memtoreg=1 and regwrite=1; total 7 cycles.
REQ-025 BRANCH with zero=1 -> pc_we=pc_src=1 in EXEC, back in FETCH after 3 cycles; with zero=0, pc_src=0.
REQ-026 Opcode 1111111 -> HALT, illegal=1, no strobes for 10 cycles with run=1; reset -> FETCH, illegal=0.
REQ-027 Reset asserted in MEM of a STORE while mem_ready=0 -> next cycle FETCH, memwrite=0, retired=0.
REQ-028 Retire 256 R-type instructions -> retired wraps to 0; with run=0 in FETCH, ir_we stays 0 and the state holds.
